// File: rtl/regfile_wb_arbiter.sv
// ----------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Write-side master for the register file. The single write port
// (wEna/wAddr/wDin) is shared between the one-cycle pipeline writeback (ALU)
// and results from long-latency units (load/mul/div).
//
// Long-latency results are first queued in a small FIFO. Each cycle the port
// is given to the ALU if it is writing; otherwise the FIFO head is drained.
// A per-register scoreboard (pending) marks destinations of in-flight
// long-latency ops so that decode can stall on RAW hazards.
//
// Optional build macro:
//   WB_STALL_CNT_EN - adds a 16-bit saturating stall_cnt output. It counts
//                     the cycles in which the FIFO held data but lost
//                     arbitration to an ALU write.
//
// Parameters:
//   DATA_W     - data width of the register file and all result buses
//   ADDR_W     - register address width (2**ADDR_W registers)
//   FIFO_DEPTH - long-latency result buffer entries (power of two, >= 2)
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   alu_wen/waddr/wdata     pipeline writeback, valid this cycle only
//   lu_valid/ready          long-latency result handshake (ready = !full)
//   lu_waddr/wdata          long-latency result destination and data
//   iss_valid/iss_waddr     long-latency op issued, with its destination
//   wEna/wAddr/wDin         registered register-file write port
//   pending                 scoreboard, bit n = register n awaits a result
//   err_waw                 sticky write-after-write diagnostic
//   stall_cnt               (WB_STALL_CNT_EN only) FIFO stall cycle count
// ----------------------------------------------------------------------------
module regfile_wb_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,

    input  logic                   alu_wen,
    input  logic [ADDR_W-1:0]      alu_waddr,
    input  logic [DATA_W-1:0]      alu_wdata,

    input  logic                   lu_valid,
    output logic                   lu_ready,
    input  logic [ADDR_W-1:0]      lu_waddr,
    input  logic [DATA_W-1:0]      lu_wdata,

    input  logic                   iss_valid,
    input  logic [ADDR_W-1:0]      iss_waddr,

    output logic                   wEna,
    output logic [ADDR_W-1:0]      wAddr,
    output logic [DATA_W-1:0]      wDin,

    output logic [(2**ADDR_W)-1:0] pending,
    output logic                   err_waw
`ifdef WB_STALL_CNT_EN
    ,
    output logic [15:0]            stall_cnt
`endif
);

    localparam int NREG  = 2**ADDR_W;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // Result FIFO storage and pointers
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] fifoAddr [FIFO_DEPTH];
    logic [DATA_W-1:0] fifoData [FIFO_DEPTH];
    logic [PTR_W-1:0]  wrPtr;
    logic [PTR_W-1:0]  rdPtr;
    logic [PTR_W:0]    count;

    logic fifoEmpty;
    logic fifoFull;
    logic aluHit;
    logic issHit;
    logic pushEn;
    logic popEn;

    logic [ADDR_W-1:0] headAddr;
    logic [DATA_W-1:0] headData;

    logic [NREG-1:0] setMask;
    logic [NREG-1:0] clrMask;
    logic [NREG-1:0] pendingNext;
    logic            wawHit;

    assign fifoEmpty = (count == '0);
    assign fifoFull  = (count == FULL_CNT);

    // Ready is derived from the current occupancy only, so a full FIFO
    // refuses a push even in a cycle where it is also being drained.
    assign lu_ready  = !fifoFull;

    // Register 0 is hard-wired: requests targeting it are dropped here.
    assign aluHit    = alu_wen && (alu_waddr != '0);
    assign issHit    = iss_valid && (iss_waddr != '0);

    // An lu result for register 0 still completes its handshake, but is
    // never stored.
    assign pushEn    = lu_valid && lu_ready && (lu_waddr != '0);

    // ALU has priority; the FIFO drains only in cycles the ALU is silent.
    assign popEn     = !aluHit && !fifoEmpty;

    assign headAddr  = fifoAddr[rdPtr];
    assign headData  = fifoData[rdPtr];

    // Data storage needs no reset: the occupancy count says what is valid.
    always_ff @(posedge clk) begin
        if (pushEn) begin
            fifoAddr[wrPtr] <= lu_waddr;
            fifoData[wrPtr] <= lu_wdata;
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (pushEn) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (popEn) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({pushEn, popEn})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Write port: registered, one cycle after source selection.
    // Address/data hold their last values when no write is issued.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wEna  <= 1'b0;
            wAddr <= '0;
            wDin  <= '0;
        end else if (aluHit) begin
            wEna  <= 1'b1;
            wAddr <= alu_waddr;
            wDin  <= alu_wdata;
        end else if (popEn) begin
            wEna  <= 1'b1;
            wAddr <= headAddr;
            wDin  <= headData;
        end else begin
            wEna  <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard. The clear is applied before the set so that an issue
    // to a register in the same cycle its older result retires leaves
    // the bit set for the new op.
    // ------------------------------------------------------------------
    always_comb begin
        setMask = '0;
        clrMask = '0;
        if (issHit) begin
            setMask[iss_waddr] = 1'b1;
        end
        if (popEn) begin
            clrMask[headAddr] = 1'b1;
        end
        pendingNext = (pending & ~clrMask) | setMask;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= pendingNext;
        end
    end

    // WAW diagnostic: a new producer for a register that still has a
    // long-latency result outstanding. The write itself proceeds.
    assign wawHit = (issHit && pending[iss_waddr]) ||
                    (aluHit && pending[alu_waddr]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_waw <= 1'b0;
        end else if (wawHit) begin
            err_waw <= 1'b1;
        end
    end

`ifdef WB_STALL_CNT_EN
    // Counts cycles where buffered results were held back by the ALU.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (aluHit && !fifoEmpty && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clk;
    logic              rst_n;
    logic              alu_wen;
    logic [ADDR_W-1:0] alu_waddr;
    logic [DATA_W-1:0] alu_wdata;
    logic              lu_valid;
    logic              lu_ready;
    logic [ADDR_W-1:0] lu_waddr;
    logic [DATA_W-1:0] lu_wdata;
    logic              iss_valid;
    logic [ADDR_W-1:0] iss_waddr;
    logic              wEna;
    logic [ADDR_W-1:0] wAddr;
    logic [DATA_W-1:0] wDin;
    logic [31:0]       pending;
    logic              err_waw;
`ifdef WB_STALL_CNT_EN
    logic [15:0]       stall_cnt;
`endif

    int compared = 0;
    int mismatched = 0;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t expQ[$];

    regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_wen   (alu_wen),
        .alu_waddr (alu_waddr),
        .alu_wdata (alu_wdata),
        .lu_valid  (lu_valid),
        .lu_ready  (lu_ready),
        .lu_waddr  (lu_waddr),
        .lu_wdata  (lu_wdata),
        .iss_valid (iss_valid),
        .iss_waddr (iss_waddr),
        .wEna      (wEna),
        .wAddr     (wAddr),
        .wDin      (wDin),
        .pending   (pending),
        .err_waw   (err_waw)
`ifdef WB_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every write seen on the port must match the next expected one.
    always @(negedge clk) begin
        if (rst_n && wEna) begin
            if (expQ.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_write: got addr %0d data %h, expected no write",
                         wAddr, wDin);
            end else begin
                wr_t e;
                e = expQ.pop_front();
                chk("write_port", {27'd0, wAddr, wDin}, {27'd0, e.addr, e.data});
            end
        end
    end

    // Inputs change 1 time unit after a rising edge and are captured at the next one.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        expQ.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        alu_wen = 1'b0; alu_waddr = '0; alu_wdata = '0;
        lu_valid = 1'b0; lu_waddr = '0; lu_wdata = '0;
        iss_valid = 1'b0; iss_waddr = '0;
        cyc(); cyc();
        rst_n = 1'b1;
        cyc(); cyc();

        // Reset / idle state
        chk("rst_wEna", 64'(wEna), 64'd0);
        chk("rst_wAddr", 64'(wAddr), 64'd0);
        chk("rst_wDin", 64'(wDin), 64'd0);
        chk("rst_pending", 64'(pending), 64'd0);
        chk("rst_lu_ready", 64'(lu_ready), 64'd1);
        chk("rst_err_waw", 64'(err_waw), 64'd0);

        // Single ALU write, one-cycle latency, then idle
        alu_wen = 1'b1; alu_waddr = 5'd5; alu_wdata = 32'hDEADBEEF;
        expect_wr(5'd5, 32'hDEADBEEF);
        cyc();
        alu_wen = 1'b0;
        chk("alu_latency_wEna", 64'(wEna), 64'd1);
        cyc();
        chk("alu_next_idle", 64'(wEna), 64'd0);

        // ALU write to register 0 is ignored
        alu_wen = 1'b1; alu_waddr = 5'd0; alu_wdata = 32'hCAFEF00D;
        cyc();
        alu_wen = 1'b0;
        chk("alu_r0_ignored", 64'(wEna), 64'd0);
        cyc();

        // Issue to r7, then its result through the FIFO
        iss_valid = 1'b1; iss_waddr = 5'd7;
        cyc();
        iss_valid = 1'b0;
        chk("pending_r7_set", 64'(pending), 64'h80);
        lu_valid = 1'b1; lu_waddr = 5'd7; lu_wdata = 32'h12345678;
        expect_wr(5'd7, 32'h12345678);
        cyc();
        lu_valid = 1'b0;
        chk("lu_no_bypass", 64'(wEna), 64'd0);
        chk("pending_r7_held", 64'(pending), 64'h80);
        cyc();
        chk("lu_write_wEna", 64'(wEna), 64'd1);
        chk("pending_r7_clear", 64'(pending), 64'h0);
        cyc();

        // ALU starves the FIFO for 4 cycles while 3 results arrive
        expect_wr(5'd10, 32'hA0A0_0010);
        expect_wr(5'd11, 32'hA0A0_0011);
        expect_wr(5'd12, 32'hA0A0_0012);
        expect_wr(5'd13, 32'hA0A0_0013);
        expect_wr(5'd3, 32'h33);
        expect_wr(5'd4, 32'h44);
        expect_wr(5'd6, 32'h66);
        alu_wen = 1'b1; alu_waddr = 5'd10; alu_wdata = 32'hA0A0_0010;
        lu_valid = 1'b1; lu_waddr = 5'd3; lu_wdata = 32'h33;
        cyc();
        alu_waddr = 5'd11; alu_wdata = 32'hA0A0_0011;
        lu_waddr = 5'd4; lu_wdata = 32'h44;
        chk("starve_ready_1", 64'(lu_ready), 64'd1);
        cyc();
        alu_waddr = 5'd12; alu_wdata = 32'hA0A0_0012;
        lu_waddr = 5'd6; lu_wdata = 32'h66;
        chk("starve_full_a", 64'(lu_ready), 64'd0);
        cyc();
        alu_waddr = 5'd13; alu_wdata = 32'hA0A0_0013;
        chk("starve_full_b", 64'(lu_ready), 64'd0);
        cyc();
        alu_wen = 1'b0;
        chk("starve_full_c", 64'(lu_ready), 64'd0);
        cyc();
        chk("starve_ready_back", 64'(lu_ready), 64'd1);
        cyc();
        lu_valid = 1'b0;
        cyc();
        cyc();
`ifdef WB_STALL_CNT_EN
        chk("stall_cnt", 64'(stall_cnt), 64'd3);
`endif
        chk("starve_drained_ready", 64'(lu_ready), 64'd1);

        // Double issue to r9 -> sticky WAW error
        iss_valid = 1'b1; iss_waddr = 5'd9;
        cyc();
        chk("waw_not_yet", 64'(err_waw), 64'd0);
        cyc();
        iss_valid = 1'b0;
        chk("waw_iss_set", 64'(err_waw), 64'd1);
        cyc(); cyc();
        chk("waw_sticky", 64'(err_waw), 64'd1);

        // Fill FIFO with results that are then discarded by reset
        iss_valid = 1'b1; iss_waddr = 5'd20;
        cyc();
        iss_waddr = 5'd21;
        alu_wen = 1'b1; alu_waddr = 5'd1; alu_wdata = 32'h0000_0001;
        lu_valid = 1'b1; lu_waddr = 5'd20; lu_wdata = 32'hAAAA_AAAA;
        expect_wr(5'd1, 32'h0000_0001);
        cyc();
        iss_valid = 1'b0;
        alu_waddr = 5'd2; alu_wdata = 32'h0000_0002;
        lu_waddr = 5'd21; lu_wdata = 32'hBBBB_BBBB;
        expect_wr(5'd2, 32'h0000_0002);
        cyc();
        alu_wen = 1'b0; lu_valid = 1'b0;
        chk("prerst_pending", 64'(pending), 64'h0030_0200);
        chk("prerst_full", 64'(lu_ready), 64'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_pending", 64'(pending), 64'd0);
        chk("midrst_wEna", 64'(wEna), 64'd0);
        chk("midrst_lu_ready", 64'(lu_ready), 64'd1);
        chk("midrst_err_waw", 64'(err_waw), 64'd0);
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) cyc();
        chk("postrst_pending", 64'(pending), 64'd0);

        // ALU write to a pending register -> WAW error, write still done
        iss_valid = 1'b1; iss_waddr = 5'd15;
        cyc();
        iss_valid = 1'b0;
        alu_wen = 1'b1; alu_waddr = 5'd15; alu_wdata = 32'h5555_5555;
        expect_wr(5'd15, 32'h5555_5555);
        cyc();
        alu_wen = 1'b0;
        chk("waw_alu_set", 64'(err_waw), 64'd1);
        chk("alu_keeps_pending", 64'(pending), 64'h0000_8000);
        lu_valid = 1'b1; lu_waddr = 5'd15; lu_wdata = 32'h7777_7777;
        expect_wr(5'd15, 32'h7777_7777);
        cyc();
        lu_waddr = 5'd0; lu_wdata = 32'hDEAD_0000;
        cyc();
        lu_valid = 1'b0;
        chk("pending_r15_clear", 64'(pending), 64'd0);

        // Issue to r0 sets nothing
        iss_valid = 1'b1; iss_waddr = 5'd0;
        cyc();
        iss_valid = 1'b0;
        chk("iss_r0_ignored", 64'(pending), 64'd0);

        for (int i = 0; i < 5; i++) cyc();
        chk("all_writes_seen", 64'(expQ.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
